// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage hazard/forwarding controller: operand and store-after-load
// forwarding, load-use stalls, redirect squash. Optional perf counters: OTTER_HAZ_PERF_EN.
module otter_hazard_ctrl #(
  parameter int RADDR_W   = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_EXT = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [RADDR_W-1:0] de_rs1_addr,
  input  logic [RADDR_W-1:0] de_rs2_addr,
  input  logic               de_rs1_used,
  input  logic               de_rs2_used,
  input  logic [RADDR_W-1:0] ex_rs1_addr,
  input  logic [RADDR_W-1:0] ex_rs2_addr,
  input  logic               ex_rs1_used,
  input  logic               ex_rs2_used,
  input  logic [RADDR_W-1:0] ex_rd_addr,
  input  logic               ex_regWrite,
  input  logic               ex_memRead,
  input  logic [RADDR_W-1:0] mem_rd_addr,
  input  logic               mem_regWrite,
  input  logic               mem_memRead,
  input  logic [RADDR_W-1:0] mem_rs2_addr,
  input  logic               mem_memWrite,
  input  logic [RADDR_W-1:0] wb_rd_addr,
  input  logic               wb_regWrite,
  input  logic               wb_memRead,
  input  logic [1:0]         pc_sel,
  output logic [1:0]         fsel1,
  output logic [1:0]         fsel2,
  output logic               sal_fwd,
  output logic               stall,
  output logic               bubble_ex,
  output logic               flush_de,
  output logic               flush_ex
`ifdef OTTER_HAZ_PERF_EN
  ,
  output logic [31:0]        perf_stall_cyc,
  output logic [31:0]        perf_flush_evt,
  output logic [31:0]        perf_fwd_evt
`endif
);

  typedef enum logic [1:0] {RUN, LDSTALL, SQUASH} state_t;

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_LAT - 1);
  localparam logic [1:0] SQUASH_RELOAD = 2'(FLUSH_EXT);
  localparam logic [RADDR_W-1:0] X0 = '0;

  state_t     state_q, state_d;
  logic [2:0] stall_cnt_q, stall_cnt_d;
  logic [1:0] squash_cnt_q, squash_cnt_d;
  logic       redirect, load_use;

  function automatic logic [1:0] fwd_sel(
    input logic               used,
    input logic [RADDR_W-1:0] a,
    input logic               m_wr,
    input logic               m_ld,
    input logic [RADDR_W-1:0] m_rd,
    input logic               w_wr,
    input logic [RADDR_W-1:0] w_rd
  );
    logic [1:0] s;
    s = 2'd0;
    if (used && a != X0) begin
      if (m_wr && !m_ld && m_rd == a) s = 2'd2;
      else if (w_wr && w_rd == a)     s = 2'd1;
    end
    return s;
  endfunction

  assign redirect = pc_sel != 2'b00;
  assign load_use = ex_memRead && ex_regWrite && ex_rd_addr != X0 &&
                    ((de_rs1_used && de_rs1_addr == ex_rd_addr) ||
                     (de_rs2_used && de_rs2_addr == ex_rd_addr));

  // Forwarding selects, outputs and next-state, all from inputs and current state
  always_comb begin
    state_d      = state_q;
    stall_cnt_d  = stall_cnt_q;
    squash_cnt_d = squash_cnt_q;
    fsel1        = 2'd0;
    fsel2        = 2'd0;
    sal_fwd      = 1'b0;
    stall        = 1'b0;
    bubble_ex    = 1'b0;
    flush_de     = 1'b0;
    flush_ex     = 1'b0;
    if (RESET) begin
      flush_de     = 1'b1;
      flush_ex     = 1'b1;
      state_d      = RUN;
      stall_cnt_d  = 3'd0;
      squash_cnt_d = 2'd0;
    end else begin
      fsel1 = fwd_sel(ex_rs1_used, ex_rs1_addr, mem_regWrite,
                      mem_memRead, mem_rd_addr, wb_regWrite, wb_rd_addr);
      fsel2 = fwd_sel(ex_rs2_used, ex_rs2_addr, mem_regWrite,
                      mem_memRead, mem_rd_addr, wb_regWrite, wb_rd_addr);
      sal_fwd = mem_memWrite && wb_memRead && wb_regWrite &&
                wb_rd_addr == mem_rs2_addr && mem_rs2_addr != X0;
      if (redirect) begin
        // Redirect wins in every state and cancels any pending stall
        flush_de    = 1'b1;
        flush_ex    = 1'b1;
        stall_cnt_d = 3'd0;
        if (FLUSH_EXT > 0) begin
          state_d      = SQUASH;
          squash_cnt_d = SQUASH_RELOAD;
        end else begin
          state_d      = RUN;
          squash_cnt_d = 2'd0;
        end
      end else begin
        unique case (state_q)
          RUN: begin
            if (load_use) begin
              stall     = 1'b1;
              bubble_ex = 1'b1;
              if (LOAD_LAT > 1) begin
                state_d     = LDSTALL;
                stall_cnt_d = STALL_RELOAD;
              end
            end
          end
          LDSTALL: begin
            stall       = 1'b1;
            bubble_ex   = 1'b1;
            stall_cnt_d = stall_cnt_q - 3'd1;
            if (stall_cnt_q <= 3'd1) begin
              state_d     = RUN;
              stall_cnt_d = 3'd0;
            end
          end
          SQUASH: begin
            flush_de     = 1'b1;
            squash_cnt_d = squash_cnt_q - 2'd1;
            if (squash_cnt_q <= 2'd1) begin
              state_d      = RUN;
              squash_cnt_d = 2'd0;
            end
          end
          default: begin
            state_d      = RUN;
            stall_cnt_d  = 3'd0;
            squash_cnt_d = 2'd0;
          end
        endcase
      end
    end
  end

  // State and counter registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= RUN;
      stall_cnt_q  <= 3'd0;
      squash_cnt_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

`ifdef OTTER_HAZ_PERF_EN
  // Saturating event counters for stall cycles, redirects and forwarding cycles
  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_stall_cyc <= 32'd0;
      perf_flush_evt <= 32'd0;
      perf_fwd_evt   <= 32'd0;
    end else begin
      if (stall && perf_stall_cyc != 32'hFFFFFFFF)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      if (redirect && perf_flush_evt != 32'hFFFFFFFF)
        perf_flush_evt <= perf_flush_evt + 32'd1;
      if ((fsel1 != 2'd0 || fsel2 != 2'd0) &&
          perf_fwd_evt != 32'hFFFFFFFF)
        perf_fwd_evt <= perf_fwd_evt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Self-checking bench for otter_hazard_ctrl (LOAD_LAT=3, FLUSH_EXT=1)
// against a countdown reference model; random plus directed scenarios.
module tb_otter_hazard_ctrl;
  localparam int AW = 5;
  localparam int LL = 3;
  localparam int FE = 1;

  logic CLK = 1'b0;
  logic RESET;
  logic [AW-1:0] de_rs1_addr, de_rs2_addr, ex_rs1_addr, ex_rs2_addr;
  logic [AW-1:0] ex_rd_addr, mem_rd_addr, mem_rs2_addr, wb_rd_addr;
  logic de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used;
  logic ex_regWrite, ex_memRead, mem_regWrite, mem_memRead, mem_memWrite;
  logic wb_regWrite, wb_memRead;
  logic [1:0] pc_sel;
  logic [1:0] fsel1, fsel2;
  logic sal_fwd, stall, bubble_ex, flush_de, flush_ex;
  logic [8:0] obs;
`ifdef OTTER_HAZ_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_evt, perf_fwd_evt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: remaining extra stall / squash cycles
  int m_stall_rem = 0, m_sq_rem = 0;
  int n_stall_rem, n_sq_rem;
  longint m_pstall = 0, m_pflush = 0, m_pfwd = 0;
  longint n_pstall, n_pflush, n_pfwd;

  always #5 CLK = ~CLK;

  assign obs = {fsel1, fsel2, sal_fwd, stall, bubble_ex, flush_de, flush_ex};

  otter_hazard_ctrl #(.RADDR_W(AW), .LOAD_LAT(LL), .FLUSH_EXT(FE)) dut (
    .CLK(CLK), .RESET(RESET),
    .de_rs1_addr(de_rs1_addr), .de_rs2_addr(de_rs2_addr),
    .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rs1_used(ex_rs1_used), .ex_rs2_used(ex_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .mem_rd_addr(mem_rd_addr),
    .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead),
    .mem_rs2_addr(mem_rs2_addr), .mem_memWrite(mem_memWrite),
    .wb_rd_addr(wb_rd_addr), .wb_regWrite(wb_regWrite),
    .wb_memRead(wb_memRead), .pc_sel(pc_sel),
    .fsel1(fsel1), .fsel2(fsel2), .sal_fwd(sal_fwd), .stall(stall),
    .bubble_ex(bubble_ex), .flush_de(flush_de), .flush_ex(flush_ex)
`ifdef OTTER_HAZ_PERF_EN
    ,
    .perf_stall_cyc(perf_stall_cyc), .perf_flush_evt(perf_flush_evt),
    .perf_fwd_evt(perf_fwd_evt)
`endif
  );

  function automatic logic [1:0] ref_fwd(input logic used,
                                         input logic [AW-1:0] a);
    if (!used || a == 0) return 2'd0;
    if (mem_regWrite && !mem_memRead && mem_rd_addr == a) return 2'd2;
    if (wb_regWrite && wb_rd_addr == a) return 2'd1;
    return 2'd0;
  endfunction

  // expected outputs for the current inputs; stages next model state
  task automatic model_step(output logic [8:0] e);
    logic [1:0] f1, f2;
    logic sal, st, fde, fex, lu;
    f1 = 0; f2 = 0; sal = 0; st = 0; fde = 0; fex = 0;
    n_stall_rem = m_stall_rem; n_sq_rem = m_sq_rem;
    n_pstall = m_pstall; n_pflush = m_pflush; n_pfwd = m_pfwd;
    lu = ex_memRead && ex_regWrite && ex_rd_addr != 0 &&
         ((de_rs1_used && de_rs1_addr == ex_rd_addr) ||
          (de_rs2_used && de_rs2_addr == ex_rd_addr));
    if (RESET) begin
      fde = 1; fex = 1;
      n_stall_rem = 0; n_sq_rem = 0;
      n_pstall = 0; n_pflush = 0; n_pfwd = 0;
    end else begin
      f1 = ref_fwd(ex_rs1_used, ex_rs1_addr);
      f2 = ref_fwd(ex_rs2_used, ex_rs2_addr);
      sal = mem_memWrite && wb_memRead && wb_regWrite &&
            wb_rd_addr == mem_rs2_addr && mem_rs2_addr != 0;
      if (pc_sel != 0) begin
        fde = 1; fex = 1;
        n_stall_rem = 0; n_sq_rem = FE;
        n_pflush = m_pflush + 1;
      end else if (m_sq_rem > 0) begin
        fde = 1; n_sq_rem = m_sq_rem - 1;
      end else if (m_stall_rem > 0) begin
        st = 1; n_stall_rem = m_stall_rem - 1;
      end else if (lu) begin
        st = 1; n_stall_rem = LL - 1;
      end
      if (st) n_pstall = m_pstall + 1;
      if (f1 != 0 || f2 != 0) n_pfwd = m_pfwd + 1;
    end
    e = {f1, f2, sal, st, st, fde, fex};
  endtask

  task automatic tick();
    m_stall_rem = n_stall_rem; m_sq_rem = n_sq_rem;
    m_pstall = n_pstall; m_pflush = n_pflush; m_pfwd = n_pfwd;
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    {de_rs1_addr, de_rs2_addr, ex_rs1_addr, ex_rs2_addr} = '0;
    {ex_rd_addr, mem_rd_addr, mem_rs2_addr, wb_rd_addr} = '0;
    {de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used} = '0;
    {ex_regWrite, ex_memRead, mem_regWrite, mem_memRead} = '0;
    {mem_memWrite, wb_regWrite, wb_memRead} = '0;
    pc_sel = 2'd0;
  endtask

  task automatic rand_inputs();
    de_rs1_addr = AW'($urandom_range(0, 3));
    de_rs2_addr = AW'($urandom_range(0, 3));
    ex_rs1_addr = AW'($urandom_range(0, 3));
    ex_rs2_addr = AW'($urandom_range(0, 3));
    ex_rd_addr = AW'($urandom_range(0, 3));
    mem_rd_addr = AW'($urandom_range(0, 3));
    mem_rs2_addr = AW'($urandom_range(0, 3));
    wb_rd_addr = AW'($urandom_range(0, 3));
    {de_rs1_used, de_rs2_used, ex_rs1_used, ex_rs2_used} = 4'($urandom);
    {ex_regWrite, ex_memRead, mem_regWrite, mem_memRead} = 4'($urandom);
    {mem_memWrite, wb_regWrite, wb_memRead} = 3'($urandom);
    pc_sel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
  endtask

  task automatic test_reset();
    logic [8:0] e;
    RESET = 1'b1;
    clear_inputs();
    model_step(e);
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      #3;
      model_step(e);
      checks++;
      if (obs !== e || obs !== 9'b0000_00011) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
    RESET = 1'b0;
    clear_inputs();
  endtask

  task automatic test_forward();
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      mem_rd_addr = 5; mem_regWrite = 1;
      ex_rs1_used = 1; ex_rs1_addr = (i == 2) ? 5'd0 : 5'd5;
      if (i >= 1) begin wb_rd_addr = 5; wb_regWrite = 1; end
      #3;
      model_step(e);
      checks++;
      if (obs !== e || fsel1 !== ((i == 2) ? 2'd0 : 2'd2)) begin
        failures++;
        $display("FAIL forward i=%0d got=%b exp=%b", i, obs, e);
      end
      tick();
    end
    clear_inputs();
    mem_rd_addr = 6; mem_regWrite = 1; mem_memRead = 1;
    wb_rd_addr = 6; wb_regWrite = 1;
    ex_rs2_used = 1; ex_rs2_addr = 6;
    #3;
    model_step(e);
    checks++;
    if (obs !== e || fsel2 !== 2'd1) begin
      failures++;
      $display("FAIL fwd_memload got=%b exp=%b", obs, e);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [8:0] e;
    clear_inputs();
    ex_memRead = 1; ex_regWrite = 1; ex_rd_addr = 7;
    de_rs2_used = 1; de_rs2_addr = 7;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin ex_memRead = 0; ex_regWrite = 0; end
      #3;
      model_step(e);
      checks++;
      if (obs !== e || stall !== (i < LL) || bubble_ex !== (i < LL)) begin
        failures++;
        $display("FAIL load_use i=%0d got=%b exp=%b", i, obs, e);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_redirect();
    logic [8:0] e;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      pc_sel = (i == 0) ? 2'd2 : 2'd0;
      #3;
      model_step(e);
      checks++;
      if (obs !== e || flush_de !== (i < 2) || flush_ex !== (i == 0)) begin
        failures++;
        $display("FAIL redirect i=%0d got=%b exp=%b", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_redirect_in_stall();
    logic [8:0] e;
    logic [4:0] want;
    clear_inputs();
    ex_memRead = 1; ex_regWrite = 1; ex_rd_addr = 3;
    de_rs1_used = 1; de_rs1_addr = 3;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin ex_memRead = 0; ex_regWrite = 0; end
      pc_sel = (i == 2) ? 2'd1 : 2'd0;
      // {stall, bubble, flush_de, flush_ex} per cycle
      case (i)
        0, 1: want = 5'b01100;
        2: want = 5'b00011;
        3: want = 5'b00010;
        default: want = 5'b00000;
      endcase
      #3;
      model_step(e);
      checks++;
      if (obs !== e || obs[4:0] !== want) begin
        failures++;
        $display("FAIL ld_redirect i=%0d got=%b exp=%b", i, obs, e);
      end
      tick();
    end
  endtask

  task automatic test_sal();
    logic [8:0] e;
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      mem_memWrite = 1; mem_rs2_addr = (i == 2) ? 5'd0 : 5'd9;
      wb_memRead = 1; wb_regWrite = 1; wb_rd_addr = (i == 0) ? 5'd9 : 5'd0;
      #3;
      model_step(e);
      checks++;
      if (obs !== e || sal_fwd !== (i == 0)) begin
        failures++;
        $display("FAIL sal i=%0d got=%b exp=%b", i, obs, e);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_squash();
    logic [8:0] e;
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      pc_sel = (i == 0) ? 2'd3 : 2'd0;
      RESET = (i == 1 || i == 2);
      #3;
      model_step(e);
      checks++;
      if (obs !== e || (i == 3 && obs !== 9'd0) ||
          ((i == 1 || i == 2) && obs !== 9'b0000_00011)) begin
        failures++;
        $display("FAIL reset_squash i=%0d got=%b exp=%b", i, obs, e);
      end
`ifdef OTTER_HAZ_PERF_EN
      if (i == 3) begin
        checks++;
        if ({perf_stall_cyc, perf_flush_evt, perf_fwd_evt} !== 96'd0) begin
          failures++;
          $display("FAIL perf_reset got=%0d/%0d/%0d exp=0/0/0",
                   perf_stall_cyc, perf_flush_evt, perf_fwd_evt);
        end
      end
`endif
      tick();
    end
    RESET = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      RESET = ($urandom_range(0, 59) == 0);
      #3;
      model_step(e);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
    RESET = 1'b0;
    clear_inputs();
`ifdef OTTER_HAZ_PERF_EN
    checks++;
    if (perf_stall_cyc !== 32'(m_pstall) || perf_flush_evt !== 32'(m_pflush) ||
        perf_fwd_evt !== 32'(m_pfwd)) begin
      failures++;
      $display("FAIL perf_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d",
               perf_stall_cyc, perf_flush_evt, perf_fwd_evt,
               m_pstall, m_pflush, m_pfwd);
    end
`endif
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_redirect();
    test_redirect_in_stall();
    test_sal();
    test_random();
    test_reset_in_squash();
    test_load_use();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
